btn_step_conditioner: RTL



---
 rtl/btn_step_conditioner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/btn_step_conditioner.sv
// Debounces a raw push-button into level/pulse/count status and a stretched step strobe.
// Latency: press/release accepted 2+DEBOUNCE_CYCLES cp edges after btn_raw settles.
// Backpressure: none; free-running, and a press arriving while step_cp is high does not reload it.
module btn_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int STRETCH_CYCLES  = 1000,
    parameter int CNT_W           = 21
) (
    input  logic       cp,
    input  logic       rst_n,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       step_cp,
    output logic [7:0] press_count
);

    localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               s1;
    logic               btn_sync;
    logic               press_evt;
    logic               release_evt;
    logic [STR_W-1:0]   str_cnt;

    // btn_raw is asynchronous to cp; only btn_sync may reach the FSM.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn_raw;
            btn_sync <= s1;
        end
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (btn_sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    release_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            if (press_evt) begin
                btn_level   <= 1'b1;
                press_count <= press_count + 8'd1;
            end else if (release_evt) begin
                btn_level <= 1'b0;
            end
        end
    end

    // Load only from idle so an overlapping press cannot extend the strobe.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            step_cp <= 1'b0;
            str_cnt <= '0;
        end else if (press_evt && !step_cp) begin
            step_cp <= 1'b1;
            str_cnt <= STR_LOAD;
        end else if (step_cp) begin
            if (str_cnt == '0) begin
                step_cp <= 1'b0;
            end else begin
                str_cnt <= str_cnt - STR_W'(1);
            end
        end
    end

endmodule
